// File: rtl/gyro_pkg.sv
// Shared types and sizing constants for the gyro heading integrator.
package gyro_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCal  = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam int unsigned CAL_N_FAST = 16;
  localparam int unsigned CAL_N_FULL = 2048;
  localparam int unsigned ACC_W_FAST = 23;
  localparam int unsigned ACC_W_FULL = 27;

endpackage

// File: rtl/gyro_heading_integ_if.sv
// Sample/control bundle between the inertial front end and the heading integrator.
interface gyro_heading_integ_if;
  logic               strt_cal;
  logic               vld;
  logic signed [15:0] yaw_rt;
  logic               moving;
  logic               lftIR;
  logic               rghtIR;
  logic               cal_done;
  logic               rdy;
  logic        [11:0] heading;

  modport master (
    output strt_cal, vld, yaw_rt, moving, lftIR, rghtIR,
    input  cal_done, rdy, heading
  );

  modport slave (
    input  strt_cal, vld, yaw_rt, moving, lftIR, rghtIR,
    output cal_done, rdy, heading
  );
endinterface

// File: rtl/yaw_offset_cal.sv
// Averages CalN yaw samples into a signed gyro offset; offset is kept across restarts.
module yaw_offset_cal #(
  parameter int unsigned CalN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               vld,
  input  logic signed [15:0] yaw_rt,
  output logic signed [15:0] offset,
  output logic               last_sample
);

  localparam int unsigned Shift = $clog2(CalN);

  logic        [11:0] cnt_q;
  logic signed [26:0] sum_q;
  logic signed [26:0] sum_d;
  logic signed [26:0] avg;
  logic signed [15:0] offset_q;

  assign sum_d       = sum_q + {{11{yaw_rt[15]}}, yaw_rt};
  assign avg         = sum_d >>> Shift;
  assign last_sample = vld && !clr && (cnt_q == 12'(CalN - 1));
  assign offset      = offset_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sum_q    <= '0;
      offset_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else if (vld) begin
      cnt_q <= cnt_q + 12'd1;
      sum_q <= sum_d;
      if (last_sample) offset_q <= avg[15:0];
    end
  end

endmodule

// File: rtl/gyro_heading_integ.sv
// Offset-calibrated yaw-rate integrator producing a wrapping 12-bit heading with IR drift nudges.
module gyro_heading_integ
  import gyro_pkg::*;
#(
  parameter int unsigned FAST_SIM = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  gyro_heading_integ_if.slave bus
);

  localparam int unsigned AccW = (FAST_SIM != 0) ? ACC_W_FAST : ACC_W_FULL;
  localparam int unsigned CalN = (FAST_SIM != 0) ? CAL_N_FAST : CAL_N_FULL;
  localparam logic [AccW-1:0] Nudge = AccW'(1) << (AccW - 14);

  state_e state_q, state_d;

  logic               cal_vld, run_vld, acc_en, acc_clr;
  logic               cal_done_d, rdy_d, cal_done_q, rdy_q;
  logic               last_sample;
  logic signed [15:0] offset;
  logic signed [16:0] diff;
  logic signed [15:0] comp;
  logic [AccW-1:0]    nudge;
  logic [AccW-1:0]    acc_q, acc_d;

  yaw_offset_cal #(
    .CalN (CalN)
  ) u_cal (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (bus.strt_cal),
    .vld         (cal_vld),
    .yaw_rt      (bus.yaw_rt),
    .offset      (offset),
    .last_sample (last_sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.strt_cal) state_d = StCal;
      StCal:   if (!bus.strt_cal && last_sample) state_d = StRun;
      StRun:   if (bus.strt_cal) state_d = StCal;
      default: state_d = StIdle;
    endcase
  end

  // strt_cal wins over a coincident vld: the sample is dropped everywhere.
  always_comb begin
    cal_vld    = (state_q == StCal) && bus.vld && !bus.strt_cal;
    run_vld    = (state_q == StRun) && bus.vld && !bus.strt_cal;
    acc_en     = run_vld && bus.moving;
    acc_clr    = last_sample;
    cal_done_d = last_sample;
    rdy_d      = run_vld;
  end

  always_comb begin
    diff = {bus.yaw_rt[15], bus.yaw_rt} - {offset[15], offset};
    comp = diff[15:0];
    if (diff[16] != diff[15]) comp = diff[16] ? 16'sh8000 : 16'sh7fff;
  end

  always_comb begin
    nudge = '0;
    unique case ({bus.lftIR, bus.rghtIR})
      2'b10:   nudge = -Nudge;
      2'b01:   nudge = Nudge;
      default: nudge = '0;
    endcase
    acc_d = acc_q + {{(AccW - 16){comp[15]}}, comp} + nudge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cal_done_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      cal_done_q <= cal_done_d;
      rdy_q      <= rdy_d;
      if (acc_clr)     acc_q <= '0;
      else if (acc_en) acc_q <= acc_d;
    end
  end

  assign bus.cal_done = cal_done_q;
  assign bus.rdy      = rdy_q;
  assign bus.heading  = acc_q[AccW-1 -: 12];

endmodule

// File: tb/tb_gyro_heading_integ.sv
// Directed bench for gyro_heading_integ with FAST_SIM=8 (N=16, 23-bit accumulator).
module tb_gyro_heading_integ;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   rdy_total;
  int   cal_total;
  int   rdy_base;
  int   cal_base;

  gyro_heading_integ_if bus ();

  gyro_heading_integ #(
    .FAST_SIM (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts pulses of the preceding cycle; read totals only after a settling edge.
  always @(posedge clk) begin
    if (bus.rdy)      rdy_total <= rdy_total + 1;
    if (bus.cal_done) cal_total <= cal_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] y);
    bus.vld    = 1'b1;
    bus.yaw_rt = y;
    @(negedge clk);
    bus.vld    = 1'b0;
  endtask

  task automatic pulse_cal();
    bus.strt_cal = 1'b1;
    @(negedge clk);
    bus.strt_cal = 1'b0;
  endtask

  task automatic mark();
    idle(2);
    rdy_base = rdy_total;
    cal_base = cal_total;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rdy_total = 0;
    cal_total = 0;
    rst_n        = 1'b0;
    bus.strt_cal = 1'b0;
    bus.vld      = 1'b0;
    bus.yaw_rt   = '0;
    bus.moving   = 1'b0;
    bus.lftIR    = 1'b0;
    bus.rghtIR   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    check("reset_cal_done", {31'd0, bus.cal_done}, 32'd0);
    check("reset_rdy", {31'd0, bus.rdy}, 32'd0);
    check("reset_heading", {20'd0, bus.heading}, 32'h000);

    send(16'h0810);
    check("idle_vld_ignored", {31'd0, bus.rdy}, 32'd0);

    // Calibration: 16 x 0x0010
    mark();
    pulse_cal();
    for (int i = 0; i < 15; i++) send(16'h0010);
    check("cal_done_early", {31'd0, bus.cal_done}, 32'd0);
    send(16'h0010);
    check("cal_done_pulse", {31'd0, bus.cal_done}, 32'd1);
    check("cal_heading", {20'd0, bus.heading}, 32'h000);
    check("cal_offset", {16'd0, dut.u_cal.offset}, 32'h0010);
    idle(1);
    check("cal_done_width", {31'd0, bus.cal_done}, 32'd0);
    idle(1);
    check("cal_no_rdy", rdy_total - rdy_base, 32'd0);
    check("cal_one_done", cal_total - cal_base, 32'd1);

    // Integration: comp=2048 adds one heading LSB per sample
    bus.moving = 1'b1;
    mark();
    send(16'h0810);
    check("int_first_rdy", {31'd0, bus.rdy}, 32'd1);
    check("int_first_heading", {20'd0, bus.heading}, 32'h001);
    idle(1);
    check("int_rdy_width", {31'd0, bus.rdy}, 32'd0);
    for (int i = 0; i < 127; i++) send(16'h0810);
    check("int_heading", {20'd0, bus.heading}, 32'h080);
    idle(2);
    check("int_rdy_count", rdy_total - rdy_base, 32'd128);

    // Hold while not moving
    bus.moving = 1'b0;
    mark();
    for (int i = 0; i < 5; i++) send(16'h0810);
    check("hold_heading", {20'd0, bus.heading}, 32'h080);
    idle(2);
    check("hold_rdy_count", rdy_total - rdy_base, 32'd5);

    // Wrap: 0x080 + 1919 = 0x7FF, then one more gives 0x800
    bus.moving = 1'b1;
    for (int i = 0; i < 1919; i++) send(16'h0810);
    check("wrap_7ff", {20'd0, bus.heading}, 32'h7ff);
    send(16'h0810);
    check("wrap_800", {20'd0, bus.heading}, 32'h800);

    // Restart in RUN with coincident vld: sample dropped, no rdy
    bus.strt_cal = 1'b1;
    bus.vld      = 1'b1;
    bus.yaw_rt   = 16'h0810;
    @(negedge clk);
    bus.strt_cal = 1'b0;
    bus.vld      = 1'b0;
    check("restart_no_rdy", {31'd0, bus.rdy}, 32'd0);
    check("restart_heading_kept", {20'd0, bus.heading}, 32'h800);
    for (int i = 0; i < 15; i++) send(16'h0010);
    check("recal_heading_untouched", {20'd0, bus.heading}, 32'h800);
    check("recal_offset_kept", {16'd0, dut.u_cal.offset}, 32'h0010);
    send(16'h0010);
    check("recal_done", {31'd0, bus.cal_done}, 32'd1);
    check("recal_heading_clr", {20'd0, bus.heading}, 32'h000);

    // Fusion: comp=0, lftIR subtracts 4 x 512
    bus.lftIR = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0010);
    check("fuse_left", {20'd0, bus.heading}, 32'hfff);
    bus.rghtIR = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0010);
    check("fuse_both", {20'd0, bus.heading}, 32'hfff);
    bus.lftIR = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0010);
    check("fuse_right", {20'd0, bus.heading}, 32'h000);
    bus.rghtIR = 1'b0;

    // Saturation: offset -32768, 0x7FFF - (-32768) clips to 32767
    pulse_cal();
    for (int i = 0; i < 16; i++) send(16'h8000);
    check("sat_offset", {16'd0, dut.u_cal.offset}, 32'h8000);
    send(16'h7fff);
    check("sat_one", {20'd0, bus.heading}, 32'h00f);
    send(16'h7fff);
    check("sat_two", {20'd0, bus.heading}, 32'h01f);

    // Reset mid-calibration
    pulse_cal();
    for (int i = 0; i < 5; i++) send(16'h0010);
    rst_n = 1'b0;
    #1;
    check("rst_cal_done", {31'd0, bus.cal_done}, 32'd0);
    check("rst_rdy", {31'd0, bus.rdy}, 32'd0);
    check("rst_heading", {20'd0, bus.heading}, 32'h000);
    check("rst_offset", {16'd0, dut.u_cal.offset}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    for (int i = 0; i < 16; i++) send(16'h0010);
    idle(2);
    check("rst_idle_no_rdy", rdy_total - rdy_base, 32'd0);
    check("rst_idle_no_cal", cal_total - cal_base, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
